// File: rtl/div_datapath_if.sv
`default_nettype none
// =============================================================================
// Module : div_datapath_if
// Desc   : Operand, step-command and result bundle between the divider
//          controller (master) and div_datapath (slave).
//          Optional macro DIV_DATAPATH_REMAINDER_EN adds the remainder result.
// Rev    : 1.0  initial release
// =============================================================================
interface div_datapath_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        add;
    logic        sub;
    logic        shiftQuotient;
    logic        nop;
    logic        Q0;
    logic        ready;
    logic        MSB;
    logic [31:0] quotient;
    logic        result_valid;
    logic        exception;
`ifdef DIV_DATAPATH_REMAINDER_EN
    logic [31:0] remainder;

    modport master (
        output start, dividend, divisor, add, sub, shiftQuotient, nop, Q0, ready,
        input  MSB, quotient, result_valid, exception, remainder
    );
    modport slave (
        input  start, dividend, divisor, add, sub, shiftQuotient, nop, Q0, ready,
        output MSB, quotient, result_valid, exception, remainder
    );
`else
    modport master (
        output start, dividend, divisor, add, sub, shiftQuotient, nop, Q0, ready,
        input  MSB, quotient, result_valid, exception
    );
    modport slave (
        input  start, dividend, divisor, add, sub, shiftQuotient, nop, Q0, ready,
        output MSB, quotient, result_valid, exception
    );
`endif
endinterface
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// =============================================================================
// Module : div_datapath
// Desc   : Signed 32-bit divider datapath driven step-by-step by an external
//          controller; sign-magnitude in, final correction and sign fix-up out.
//          Optional macro DIV_DATAPATH_REMAINDER_EN adds the remainder output.
// Rev    : 1.0  initial release
// =============================================================================
module div_datapath (
    input  wire logic     clock,
    input  wire logic     reset,
    div_datapath_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [32:0] r_a;
    logic [31:0] r_q;
    logic [31:0] r_b;
    logic        r_sign_q;
    logic        r_dz;
    logic        r_ready_d;
    logic [31:0] r_quotient;
    logic        r_result_valid;
    logic        r_exception;
`ifdef DIV_DATAPATH_REMAINDER_EN
    logic        r_sign_r;
    logic [31:0] r_remainder;
    logic [31:0] w_rem_final;
`endif

    logic        w_busy;
    logic        w_ready_rise;
    logic        w_hold;
    logic [31:0] w_dividend_mag;
    logic [31:0] w_divisor_mag;
    logic [31:0] w_q_step;
    logic [31:0] w_q_final;
    logic [32:0] w_a_base;
    logic [32:0] w_a_step;
    logic [32:0] w_a_corr;

    always_comb begin
        w_busy         = (r_state == S_BUSY);
        w_ready_rise   = bus.ready & ~r_ready_d;
        // Negating 0x80000000 wraps to itself, which is the correct unsigned 2^31
        w_dividend_mag = bus.dividend[31] ? -bus.dividend : bus.dividend;
        w_divisor_mag  = bus.divisor[31]  ? -bus.divisor  : bus.divisor;

        w_a_base = bus.shiftQuotient ? {r_a[31:0], r_q[31]} : r_a;
        w_q_step = bus.shiftQuotient ? {r_q[30:0], bus.Q0} : r_q;
        w_hold   = bus.nop | (bus.add & bus.sub);
        w_a_step = w_a_base;
        if (!w_hold) begin
            if (bus.add) begin
                w_a_step = w_a_base + {1'b0, r_b};
            end else if (bus.sub) begin
                w_a_step = w_a_base - {1'b0, r_b};
            end
        end
        w_a_corr = r_a[32] ? (r_a + {1'b0, r_b}) : r_a;

        w_q_final = r_dz ? 32'd0 : (r_sign_q ? -r_q : r_q);
`ifdef DIV_DATAPATH_REMAINDER_EN
        w_rem_final = r_dz ? 32'd0 : (r_sign_r ? -r_a[31:0] : r_a[31:0]);
`endif
    end

    // A start always wins, including over a coincident ready rise
    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = S_BUSY;
        end else begin
            case (r_state)
                S_BUSY:  if (w_ready_rise) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a            <= '0;
            r_q            <= '0;
            r_b            <= '0;
            r_sign_q       <= 1'b0;
            r_dz           <= 1'b0;
            r_ready_d      <= 1'b0;
            r_quotient     <= '0;
            r_result_valid <= 1'b0;
            r_exception    <= 1'b0;
`ifdef DIV_DATAPATH_REMAINDER_EN
            r_sign_r       <= 1'b0;
            r_remainder    <= '0;
`endif
        end else begin
            r_ready_d      <= bus.ready;
            r_result_valid <= 1'b0;
            if (bus.start) begin
                r_a         <= '0;
                r_q         <= w_dividend_mag;
                r_b         <= w_divisor_mag;
                r_sign_q    <= bus.dividend[31] ^ bus.divisor[31];
                r_dz        <= (bus.divisor == 32'd0);
                r_exception <= 1'b0;
`ifdef DIV_DATAPATH_REMAINDER_EN
                r_sign_r    <= bus.dividend[31];
`endif
            end else if (w_busy) begin
                if (w_ready_rise) begin
                    r_a <= w_a_corr;
                end else begin
                    r_a <= w_a_step;
                    r_q <= w_q_step;
                end
            end else if (r_state == S_DONE) begin
                r_quotient     <= w_q_final;
                r_result_valid <= 1'b1;
                r_exception    <= r_dz;
`ifdef DIV_DATAPATH_REMAINDER_EN
                r_remainder    <= w_rem_final;
`endif
            end
        end
    end

    assign bus.MSB          = r_a[32];
    assign bus.quotient     = r_quotient;
    assign bus.result_valid = r_result_valid;
    assign bus.exception    = r_exception;
`ifdef DIV_DATAPATH_REMAINDER_EN
    assign bus.remainder    = r_remainder;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_datapath.sv
`default_nettype none
// =============================================================================
// Module : tb_div_datapath
// Desc   : Directed bench for div_datapath acting as a non-restoring divider
//          controller; table of signed divisions plus abort/reset corner cases.
// Rev    : 1.0  initial release
// =============================================================================
module tb_div_datapath;
    typedef struct {
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_exc;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rv_count = 0;
    logic [32:0] m_r;
    logic [31:0] m_q;
    logic [31:0] m_b;
    vec_t        vecs [11];

    div_datapath_if bus ();

    div_datapath dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.result_valid === 1'b1) rv_count++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? -x : x;
    endfunction

    task automatic clear_cmds();
        bus.add = 1'b0; bus.sub = 1'b0; bus.shiftQuotient = 1'b0; bus.nop = 1'b0; bus.Q0 = 1'b0;
    endtask

    task automatic begin_op(input logic [31:0] n, input logic [31:0] d);
        bus.start = 1'b1; bus.dividend = n; bus.divisor = d;
        tick();
        bus.start = 1'b0;
        m_r = '0; m_q = mag(n); m_b = mag(d);
    endtask

    // Controller model: picks add/sub from the partial-remainder sign and
    // supplies the quotient bit that this step produces.
    task automatic do_steps(input int n);
        logic [32:0] sh, nr;
        for (int i = 0; i < n; i++) begin
            check($sformatf("msb_step%0d", i), {31'd0, bus.MSB}, {31'd0, m_r[32]});
            sh = {m_r[31:0], m_q[31]};
            if (m_r[32]) begin
                nr = sh + {1'b0, m_b}; bus.add = 1'b1; bus.sub = 1'b0;
            end else begin
                nr = sh - {1'b0, m_b}; bus.add = 1'b0; bus.sub = 1'b1;
            end
            bus.shiftQuotient = 1'b1; bus.nop = 1'b0; bus.Q0 = ~nr[32];
            m_r = nr; m_q = {m_q[30:0], ~nr[32]};
            tick();
        end
        clear_cmds();
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp_q,
                             input logic [31:0] exp_r, input logic exp_exc);
        int lat;
        int rv0;
        check({tag, "_msb_final"}, {31'd0, bus.MSB}, {31'd0, m_r[32]});
        rv0 = rv_count;
        bus.ready = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.result_valid !== 1'b1 && lat < 6);
        check({tag, "_latency"}, lat, 32'd2);
        check({tag, "_quotient"}, bus.quotient, exp_q);
        check({tag, "_exception"}, {31'd0, bus.exception}, {31'd0, exp_exc});
`ifdef DIV_DATAPATH_REMAINDER_EN
        check({tag, "_remainder"}, bus.remainder, exp_r);
`else
        if (exp_r === 32'hxxxxxxxx) $display("unexpected unknown remainder in table");
`endif
        tick();
        bus.ready = 1'b0;
        check({tag, "_rv_pulses"}, rv_count - rv0, 32'd1);
    endtask

    initial begin
        int rv_save;
        vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
        vecs[4]  = '{32'd5,         32'd0,         32'd0,         32'd0,         1'b1};
        vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[6]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[7]  = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0};
        vecs[8]  = '{32'hFFFFFFFF,  32'h80000000,  32'd0,         32'hFFFFFFFF,  1'b0};
        vecs[9]  = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0};
        vecs[10] = '{32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0};

        // Reset must override a simultaneous start and step commands
        reset = 1'b1; bus.ready = 1'b0;
        bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd0;
        bus.add = 1'b0; bus.sub = 1'b1; bus.shiftQuotient = 1'b1; bus.nop = 1'b0; bus.Q0 = 1'b1;
        tick(); tick();
        reset = 1'b0; bus.start = 1'b0; clear_cmds();
        tick();
        check("rst_msb", {31'd0, bus.MSB}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_rv", {31'd0, bus.result_valid}, 32'd0);
        check("rst_exception", {31'd0, bus.exception}, 32'd0);
`ifdef DIV_DATAPATH_REMAINDER_EN
        check("rst_remainder", bus.remainder, 32'd0);
`endif
        rv_save = rv_count;
        bus.ready = 1'b1;
        tick(); tick(); tick();
        bus.ready = 1'b0;
        tick();
        check("rst_not_busy", rv_count - rv_save, 32'd0);

        for (int i = 0; i < 11; i++) begin
            begin_op(vecs[i].dividend, vecs[i].divisor);
            check($sformatf("v%0d_exc_cleared", i), {31'd0, bus.exception}, 32'd0);
            do_steps(32);
            finish_op($sformatf("v%0d", i), vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_exc);
        end

        // Idle: step commands and a ready rise must be ignored
        rv_save = rv_count;
        bus.sub = 1'b1; bus.shiftQuotient = 1'b1; bus.Q0 = 1'b1;
        tick(); tick(); tick();
        clear_cmds();
        bus.ready = 1'b1;
        tick(); tick(); tick();
        bus.ready = 1'b0;
        tick();
        check("idle_msb", {31'd0, bus.MSB}, 32'd0);
        check("idle_quotient", bus.quotient, 32'hC0000000);
        check("idle_no_rv", rv_count - rv_save, 32'd0);

        // Reset in the middle of 100/7, then 9/3
        rv_save = rv_count;
        begin_op(32'd100, 32'd7);
        do_steps(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("midrst_msb", {31'd0, bus.MSB}, 32'd0);
        check("midrst_quotient", bus.quotient, 32'd0);
        check("midrst_no_rv", rv_count - rv_save, 32'd0);
        begin_op(32'd9, 32'd3);
        do_steps(32);
        finish_op("midrst_9_3", 32'd3, 32'd0, 1'b0);

        // Restart at step 5 of 100/7 with 50/5
        rv_save = rv_count;
        begin_op(32'd100, 32'd7);
        do_steps(5);
        begin_op(32'd50, 32'd5);
        do_steps(32);
        finish_op("abort_50_5", 32'd10, 32'd0, 1'b0);
        check("abort_total_rv", rv_count - rv_save, 32'd1);

        // Start coincident with a ready rise: start wins, no result produced
        begin_op(32'd100, 32'd7);
        do_steps(32);
        rv_save = rv_count;
        bus.ready = 1'b1; bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        tick();
        bus.start = 1'b0;
        m_r = '0; m_q = 32'd9; m_b = 32'd3;
        tick(); tick(); tick();
        bus.ready = 1'b0;
        tick();
        check("startprio_no_rv", rv_count - rv_save, 32'd0);
        check("startprio_msb", {31'd0, bus.MSB}, 32'd0);
        do_steps(32);
        finish_op("startprio_9_3", 32'd3, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/div_datapath.md
DIV_DATAPATH -- requirements
Module: div_datapath

Interface
REQ-001: Module SHALL have one clock and a synchronous, active-high reset; ports are clock and reset.
REQ-002: clock  in  1  rising-edge clock for all state.
REQ-003: reset  in  1  synchronous, active-high; clears all state.
REQ-004: start  in  1  one-cycle pulse; captures operands and begins a division.
REQ-005: dividend  in  32  signed two's-complement numerator, sampled on start.
REQ-006: divisor  in  32  signed two's-complement denominator, sampled on start.
REQ-007: add, sub, shiftQuotient, nop  in  1 each  per-cycle step commands from the divider controller.
REQ-008: Q0  in  1  quotient bit from the controller, written at Q[0] on shift cycles.
REQ-009: ready  in  1  controller completion flag; it triggers final correction when it rises.
REQ-010: MSB  out  1  partial-remainder sign, A[32], driven from the register with no combinational path from the inputs.
REQ-011: quotient  out  32  signed result, held until the next start.
REQ-012: result_valid  out  1  one-cycle pulse when quotient (and remainder) are final.
REQ-013: exception  out  1  divide-by-zero flag, valid with result_valid and held until the next start.

Function
REQ-014: State SHALL be A (33-bit partial remainder), Q (32-bit), B (32-bit magnitude divisor), sign_q, sign_r, dz, busy and ready_d (delayed ready).
REQ-015: On start: A=0, Q=|dividend|, B=|divisor|, sign_q=dividend[31]^divisor[31], sign_r=dividend[31], dz=(divisor==0), busy=1, exception=0.
REQ-016: |x| of 0x80000000 SHALL be 0x80000000, treated as unsigned 2^31.
REQ-017: Step with busy=1 and shiftQuotient=1: {A,Q} shifts left by one, Q[0]<=Q0, then A<=A+B if add, or A<=A-B if sub.
REQ-018: Step with busy=1 and shiftQuotient=0: A<=A+B if add, A<=A-B if sub, and Q is held.
REQ-019: nop=1, or add and sub both asserted, SHALL hold A and Q; shiftQuotient still applies when asserted.
REQ-020: All arithmetic on A SHALL be 33-bit with B zero-extended; the carry-out is discarded.
REQ-021: On a ready rising edge (ready=1, ready_d=0) while busy=1, correction SHALL occur: if A[32]=1 then A<=A+B; busy<=0.
REQ-022: Cycle after correction: quotient<=sign_q ? -Q : Q; remainder<=sign_r ? -A[31:0] : A[31:0]; result_valid=1 for one cycle; exception<=dz.
REQ-023: If dz=1, quotient and remainder SHALL be 0 regardless of the datapath contents.
REQ-024: Latency SHALL be 2 cycles from the ready rise to result_valid.
REQ-025: Step commands received while busy=0 SHALL be ignored.
REQ-026: A start received while busy=1 SHALL abort the current operation and reload; no result_valid is produced for the aborted operation.
REQ-027: A start in the same cycle as a ready rise SHALL take priority; correction is skipped.
REQ-028: 0x80000000 / -1 SHALL yield quotient 0x80000000 (wrap) with exception=0.

Reset
REQ-029: On reset=1 at a clock edge: A, Q, B, quotient=0; MSB=0; result_valid=0; exception=0; busy=0; ready_d=0; remainder=0.
REQ-030: Reset SHALL override start and all step commands in the same cycle; reset mid-operation SHALL discard the operation with no result_valid.

Configuration
REQ-031: With macro DIV_DATAPATH_REMAINDER_EN defined, output port remainder (out, 32) SHALL exist and be set per REQ-022/023.
REQ-032: Without DIV_DATAPATH_REMAINDER_EN, the remainder port and the sign_r register SHALL be absent; the correction add of REQ-021 is still performed; quotient behaviour is identical.

Verification
REQ-033: 100 / 7 with a paired controller -> quotient 14, remainder 2, exception 0, result_valid 2 cycles after the ready rise.
REQ-034: -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2; 100 / -7 -> quotient -14, remainder 2.
REQ-035: 5 / 0 -> exception 1, quotient 0, remainder 0, single result_valid pulse.
REQ-036: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, exception 0.
REQ-037: reset at step 10 of 100/7, then 9/3 -> no result_valid for the first operation; second gives quotient 3, remainder 0.
REQ-038: second start at step 5 of 100/7 with 50/5 -> only one result_valid, quotient 10, remainder 0.
